carry_chain_bist: RTL and testbench
===================================

# carry_chain_bist

Built-in self-test driver and checker for the CLB carry chain. It drives the `a`, `b` and chain-input `cin` of a string of CHAIN_LEN carry-follower stages, waits for the ripple to settle, captures every stage's `cout`, and compares the result against a golden model. A stage's output follows its `b` input when its carry-in is 1 and its `a` input when its carry-in is 0. The block sits beside each CLB's fabric, driven from the PMU test controller, and reports pass/fail with a failure count and the first failing pattern index.

## Interface
- CHAIN_LEN, 10: number of carry-follower stages in the chain; legal range 1..15.
- NUM_PATTERNS, 256: number of pseudo-random patterns applied per run; legal range 1..65535.
- SETTLE, 2: number of wait cycles between driving a pattern and sampling it; legal range 0..15.
- SEED, 32'hACE1_2023: LFSR seed; must be nonzero.
- clk  input  1  single block clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse that begins a run; ignored while busy.
- chain_a  output  CHAIN_LEN  per-stage `a` input (bit i goes to stage i).
- chain_b  output  CHAIN_LEN  per-stage `b` input.
- chain_cin  output  1  carry-in of stage 0.
- chain_cout  input  CHAIN_LEN  `cout` of every stage; bit i is the carry-in of stage i+1.
- busy  output  1  high from the cycle after an accepted start until DONE.
- done  output  1  one-cycle pulse at the end of a run.
- pass  output  1  valid from `done` until the next start; high iff fail_count==0.
- fail_count  output  16  number of mismatching patterns; saturates at 16'hFFFF.
- first_fail_idx  output  16  index of the first mismatching pattern; 16'hFFFF if none.

## Operation
- States: IDLE, DRIVE, SETTLE_WAIT, CHECK, DONE.
- IDLE:
  - `start` resets the LFSR to SEED, clears the pattern index, fail_count and pass, and sets first_fail_idx=16'hFFFF.
  - Next state is DRIVE.
- DRIVE:
  - Register chain_a = lfsr[CHAIN_LEN-1:0], chain_b = lfsr[2*CHAIN_LEN-1:CHAIN_LEN], chain_cin = lfsr[2*CHAIN_LEN].
  - Next state is SETTLE_WAIT, or CHECK directly when SETTLE==0.
- SETTLE_WAIT:
  - A 4-bit counter runs SETTLE cycles, then the block moves to CHECK.
  - The outputs hold their values throughout.
- CHECK:
  - Compute the expected vector: c[-1]=chain_cin; exp[i] = c[i-1] ? chain_b[i] : chain_a[i]; c[i]=exp[i]. The model uses the registered drive values, not the LFSR.
  - On mismatch (chain_cout != exp):
    - fail_count increments, saturating at 16'hFFFF.
    - If first_fail_idx==16'hFFFF, load it with the current index.
  - Advance the LFSR one step and increment the index.
  - If index==NUM_PATTERNS-1, go to DONE; otherwise go to DRIVE.
- DONE:
  - Pulse `done`, set pass=(fail_count==0), drop busy, return to IDLE.
  - Results hold until the next accepted start.
- LFSR: 32-bit Galois, taps x^32+x^22+x^2+x+1, shifting right.
- Widths: fail_count and the index are 16 bits; the index never wraps because the run ends at NUM_PATTERNS-1.

## Timing
- Reset values: chain_a=0, chain_b=0, chain_cin=0, busy=0, done=0, pass=0, fail_count=0, first_fail_idx=16'hFFFF; state is IDLE.
- `start` is sampled in IDLE only; busy rises in the next cycle.
- Per-pattern cost is 2+SETTLE cycles, so a run takes NUM_PATTERNS*(2+SETTLE)+1 cycles from start to the done pulse.
- chain_cout is sampled in the CHECK cycle, SETTLE+1 cycles after the drive registers update.
  - The fabric's chain delay must fit within (SETTLE+1) clock periods.
- `start` arriving in the same cycle as `done` is ignored; a new start is accepted from the following IDLE cycle.
- Reset mid-run aborts immediately: every output returns to its reset value and no done pulse is produced.

## Structure
- Shared package `carry_bist_pkg`:
  - the state enum;
  - LFSR tap constant;
  - FAIL_NONE=16'hFFFF;
  - function `carry_chain_model(a, b, cin)` returning the expected CHAIN_LEN-bit vector. The same function is used by the bench scoreboard.
- One sub-module: `carry_bist_lfsr` (seed load, step enable, 32-bit state out).
- The FSM, counters and checker live in the top module.

## Test plan
- Ideal chain model in the bench, CHAIN_LEN=10, NUM_PATTERNS=256, SETTLE=2, start pulse -> done exactly 1025 cycles after start; pass=1, fail_count=0, first_fail_idx=16'hFFFF.
- chain_cout[3] stuck at 0, NUM_PATTERNS=16 -> fail_count equals the count of patterns where the model gives exp[3]=1 (scoreboard-computed), and first_fail_idx is the first such index.
- Bench chain delay of 3 cycles with SETTLE=2 -> no failures; same delay with SETTLE=1 -> fail_count>0 whenever the pattern changes the vector.
- rst_n asserted on cycle 300 of a run, then released, then start -> outputs at reset values during reset; the new run completes with done after 1025 cycles and identical results.
- Second start while busy and start coincident with done -> both ignored; exactly one done pulse.
- CHAIN_LEN=1, SETTLE=0, NUM_PATTERNS=1 -> done 3 cycles after start; chain_cin drives lfsr bit 2 of SEED.

Source files
------------

// File: rtl/carry_bist_pkg.sv
// carry_bist_pkg: shared FSM states, constants and golden carry-follower model
package carry_bist_pkg;
  typedef enum logic [2:0] {IDLE, DRIVE, SETTLE_WAIT, CHECK, DONE} state_e;
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [15:0] FAIL_NONE = 16'hFFFF;
  localparam int MAX_LEN = 15;
  // Each stage passes b when its carry-in is 1, a otherwise; its output is the next carry-in
  function automatic logic [MAX_LEN-1:0] carry_chain_model(
    input logic [MAX_LEN-1:0] a,
    input logic [MAX_LEN-1:0] b,
    input logic               cin
  );
    logic [MAX_LEN-1:0] r;
    logic c;
    c = cin;
    for (int i = 0; i < MAX_LEN; i++) begin
      r[i] = c ? b[i] : a[i];
      c = r[i];
    end
    return r;
  endfunction
endpackage

// File: rtl/carry_bist_lfsr.sv
// carry_bist_lfsr: 32-bit right-shifting Galois LFSR with seed load and step enable
module carry_bist_lfsr import carry_bist_pkg::*; #(
  parameter logic [31:0] SEED = 32'hACE1_2023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        step_i,
  output logic [31:0] state_o
);
  logic [31:0] lfsr_q, lfsr_d;
  always_comb lfsr_d = load_i ? SEED : step_i ? ((lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 32'd0)) : lfsr_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) lfsr_q <= SEED;
    else lfsr_q <= lfsr_d;
  assign state_o = lfsr_q;
endmodule

// File: rtl/carry_chain_bist.sv
// carry_chain_bist: drives pseudo-random patterns into a carry-follower chain and
// checks every stage's cout against the golden model after a settle delay
module carry_chain_bist import carry_bist_pkg::*; #(
  parameter int          CHAIN_LEN    = 10,
  parameter int          NUM_PATTERNS = 256,
  parameter int          SETTLE       = 2,
  parameter logic [31:0] SEED         = 32'hACE1_2023
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [CHAIN_LEN-1:0] chain_a,
  output logic [CHAIN_LEN-1:0] chain_b,
  output logic                 chain_cin,
  input  logic [CHAIN_LEN-1:0] chain_cout,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [15:0]          fail_count,
  output logic [15:0]          first_fail_idx
);
  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [15:0] idx_q, idx_d, fail_q, fail_d, ffi_q, ffi_d;
  logic pass_q, pass_d, cin_q, cin_d;
  logic [CHAIN_LEN-1:0] a_q, a_d, b_q, b_d, exp_v;
  logic [31:0] lfsr;
  logic [2*CHAIN_LEN:0] pat;
  logic accept, last, mism;
  assign accept = state_q == IDLE && start;
  assign last = idx_q == 16'(NUM_PATTERNS - 1);
  assign pat = (2*CHAIN_LEN+1)'(lfsr);
  // The model sees the registered drive values, so it matches what the fabric saw
  assign exp_v = CHAIN_LEN'(carry_chain_model(MAX_LEN'(a_q), MAX_LEN'(b_q), cin_q));
  assign mism = chain_cout != exp_v;
  carry_bist_lfsr #(.SEED(SEED)) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (accept),
    .step_i (state_q == CHECK),
    .state_o(lfsr)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      fail_q  <= '0;
      ffi_q   <= FAIL_NONE;
      pass_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      fail_q  <= fail_d;
      ffi_q   <= ffi_d;
      pass_q  <= pass_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
    end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:        state_d = start ? DRIVE : IDLE;
      DRIVE:       state_d = (SETTLE == 0) ? CHECK : SETTLE_WAIT;
      SETTLE_WAIT: state_d = (cnt_q == 4'(SETTLE - 1)) ? CHECK : SETTLE_WAIT;
      CHECK:       state_d = last ? DONE : DRIVE;
      DONE:        state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end
  always_comb begin
    cnt_d  = (state_q == SETTLE_WAIT) ? cnt_q + 4'd1 : 4'd0;
    a_d    = (state_q == DRIVE) ? pat[CHAIN_LEN-1:0] : a_q;
    b_d    = (state_q == DRIVE) ? pat[2*CHAIN_LEN-1:CHAIN_LEN] : b_q;
    cin_d  = (state_q == DRIVE) ? pat[2*CHAIN_LEN] : cin_q;
    idx_d  = accept ? 16'd0 : (state_q == CHECK) ? idx_q + 16'd1 : idx_q;
    fail_d = accept ? 16'd0 : (state_q == CHECK && mism && fail_q != 16'hFFFF) ? fail_q + 16'd1 : fail_q;
    ffi_d  = accept ? FAIL_NONE : (state_q == CHECK && mism && ffi_q == FAIL_NONE) ? idx_q : ffi_q;
    pass_d = accept ? 1'b0 : (state_q == DONE) ? fail_q == 16'd0 : pass_q;
  end
  always_comb begin
    busy           = state_q == DRIVE || state_q == SETTLE_WAIT || state_q == CHECK;
    done           = state_q == DONE;
    pass           = (state_q == DONE) ? fail_q == 16'd0 : pass_q;
    fail_count     = fail_q;
    first_fail_idx = ffi_q;
    chain_a        = a_q;
    chain_b        = b_q;
    chain_cin      = cin_q;
  end
endmodule

// File: tb/tb_carry_chain_bist.sv
// tb_carry_chain_bist: four BIST instances against ideal, stuck-at and slow chain emulations
module tb_carry_chain_bist;
  import carry_bist_pkg::*;
  localparam logic [31:0] SEED_TB = 32'hACE1_2023;
  typedef struct {
    int k; int mode; int busy_at; bit at_done; int cyc; int fc; int ff;
  } run_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] start, busy_w, done_w, pass_w;
  logic [15:0] fc_w [4];
  logic [15:0] ff_w [4];
  logic [9:0] a0, b0, cout0, a1, b1, cout1, m1, a2, b2, cout2, m2;
  logic [9:0] d1a = '0, d1b = '0, d2a = '0, d2b = '0;
  logic [0:0] a3, b3, cout3;
  logic cin0, cin1, cin2, cin3;
  int mode_b = 0, errs = 0, checks = 0;
  logic [9:0] cap_a [2];
  logic [9:0] cap_b [2];
  logic cap_c [2];
  always #5 clk = ~clk;

  assign cout0 = 10'(carry_chain_model(15'(a0), 15'(b0), cin0));
  assign m1 = 10'(carry_chain_model(15'(a1), 15'(b1), cin1));
  assign m2 = 10'(carry_chain_model(15'(a2), 15'(b2), cin2));
  assign cout1 = (mode_b == 1) ? (m1 & ~10'h008) : (mode_b == 2) ? d1b : m1;
  assign cout2 = d2b;
  assign cout3 = 1'(carry_chain_model(15'(a3), 15'(b3), cin3));
  // Slow chain: cout settles two edges after a drive, i.e. within the third period
  always @(posedge clk) begin
    d1a <= m1; d1b <= d1a; d2a <= m2; d2b <= d2a;
  end

  carry_chain_bist #(.CHAIN_LEN(10), .NUM_PATTERNS(256), .SETTLE(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .chain_a(a0), .chain_b(b0), .chain_cin(cin0),
    .chain_cout(cout0), .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
    .fail_count(fc_w[0]), .first_fail_idx(ff_w[0]));
  carry_chain_bist #(.CHAIN_LEN(10), .NUM_PATTERNS(16), .SETTLE(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .chain_a(a1), .chain_b(b1), .chain_cin(cin1),
    .chain_cout(cout1), .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
    .fail_count(fc_w[1]), .first_fail_idx(ff_w[1]));
  carry_chain_bist #(.CHAIN_LEN(10), .NUM_PATTERNS(16), .SETTLE(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .chain_a(a2), .chain_b(b2), .chain_cin(cin2),
    .chain_cout(cout2), .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]),
    .fail_count(fc_w[2]), .first_fail_idx(ff_w[2]));
  carry_chain_bist #(.CHAIN_LEN(1), .NUM_PATTERNS(1), .SETTLE(0)) dut_d (
    .clk(clk), .rst_n(rst_n), .start(start[3]), .chain_a(a3), .chain_b(b3), .chain_cin(cin3),
    .chain_cout(cout3), .busy(busy_w[3]), .done(done_w[3]), .pass(pass_w[3]),
    .fail_count(fc_w[3]), .first_fail_idx(ff_w[3]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  // mode 1: cout[3] stuck at 0; mode 2: sample sees the previous pattern's vector
  task automatic score(input int L, input int n, input int mode, output int fc, output int ff);
    logic [31:0] s;
    logic [14:0] mask, e, prev;
    s = SEED_TB; mask = 15'((32'd1 << L) - 1); prev = '0; fc = 0; ff = 'hFFFF;
    for (int p = 0; p < n; p++) begin
      e = carry_chain_model(15'(s) & mask, 15'(s >> L) & mask, s[2*L]) & mask;
      if ((mode == 1) ? e[3] : (mode == 2) ? (e != prev) : 1'b0) begin
        fc++;
        if (ff == 'hFFFF) ff = p;
      end
      prev = e;
      s = lfsr_step(s);
    end
  endtask

  task automatic run(input int k, input int busy_at, input bit at_done, output int cyc, output logic pd);
    int seen;
    @(negedge clk) start[k] = 1'b1;
    @(negedge clk) start[k] = 1'b0;
    cyc = 1;
    chk($sformatf("dut%0d_busy_rise", k), busy_w[k], 1);
    while (!done_w[k] && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      start[k] = (cyc == busy_at);
      if (k == 0 && (cyc == 2 || cyc == 6)) begin
        cap_a[cyc/4] = a0; cap_b[cyc/4] = b0; cap_c[cyc/4] = cin0;
      end
    end
    pd = pass_w[k];
    start[k] = at_done;
    @(negedge clk) start[k] = 1'b0;
    chk($sformatf("dut%0d_done_pulse", k), done_w[k], 0);
    chk($sformatf("dut%0d_busy_drop", k), busy_w[k], 0);
    if (at_done) begin
      seen = 0;
      repeat (6) begin
        @(negedge clk);
        seen += int'(busy_w[k] | done_w[k]);
      end
      chk("start_at_done_ignored", seen, 0);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_a"}, a0, 0);
    chk({tag, "_b"}, b0, 0);
    chk({tag, "_cin"}, cin0, 0);
    chk({tag, "_busy"}, busy_w[0], 0);
    chk({tag, "_done"}, done_w[0], 0);
    chk({tag, "_pass"}, pass_w[0], 0);
    chk({tag, "_fc"}, fc_w[0], 0);
    chk({tag, "_ff"}, ff_w[0], 16'hFFFF);
  endtask

  initial begin
    run_t runs [5];
    int cyc, fc, ff;
    logic pd;
    logic [31:0] seed;
    seed = SEED_TB;
    runs[0] = '{2, 2, 0, 0, 49, 0, 0};
    score(10, 16, 2, fc, ff);
    runs[0].fc = fc; runs[0].ff = ff;
    runs[1] = '{0, 0, 500, 1, 1025, 0, 'hFFFF};
    runs[2] = '{1, 1, 0, 0, 65, 0, 0};
    score(10, 16, 1, fc, ff);
    runs[2].fc = fc; runs[2].ff = ff;
    runs[3] = '{1, 2, 0, 0, 65, 0, 'hFFFF};
    runs[4] = '{3, 0, 0, 0, 3, 0, 'hFFFF};
    start = '0;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (runs[i].k == 1) mode_b = runs[i].mode;
      run(runs[i].k, runs[i].busy_at, runs[i].at_done, cyc, pd);
      chk($sformatf("run%0d_cycles", i), cyc, runs[i].cyc);
      chk($sformatf("run%0d_pass_at_done", i), pd, runs[i].fc == 0);
      chk($sformatf("run%0d_pass_held", i), pass_w[runs[i].k], runs[i].fc == 0);
      chk($sformatf("run%0d_fail_count", i), fc_w[runs[i].k], runs[i].fc);
      chk($sformatf("run%0d_first_fail", i), ff_w[runs[i].k], runs[i].ff);
    end
    chk("slow_chain_fails_nonzero", fc_w[2] != 16'd0, 1);
    chk("pat0_a", cap_a[0], 10'h023);
    chk("pat0_b", cap_b[0], 10'h048);
    chk("pat0_cin", cap_c[0], 0);
    chk("pat1_a", cap_a[1], 10'h012);
    chk("pat1_b", cap_b[1], 10'h024);
    chk("pat1_cin", cap_c[1], 1);
    chk("len1_a", a3, seed[0]);
    chk("len1_b", b3, seed[1]);
    chk("len1_cin", cin3, seed[2]);
    @(negedge clk) start[0] = 1'b1;
    @(negedge clk) start[0] = 1'b0;
    repeat (299) @(negedge clk);
    chk("abort_busy_before", busy_w[0], 1);
    rst_n = 1'b0;
    #1;
    chk_reset("abort");
    @(negedge clk);
    chk_reset("abort_held");
    rst_n = 1'b1;
    run(0, 0, 0, cyc, pd);
    chk("rerun_cycles", cyc, 1025);
    chk("rerun_pass", pd, 1);
    chk("rerun_fc", fc_w[0], 0);
    chk("rerun_ff", ff_w[0], 16'hFFFF);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
